// File: rtl/bus_dma_master.sv
// Block-copy bus master: requests the bus, then reads one word and writes it back
// per iteration until the programmed count is exhausted.
module bus_dma_master #(
    parameter int AW = 8,
    parameter int DW = 32,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic [AW-1:0] src_addr,
    input  logic [AW-1:0] dst_addr,
    input  logic [CW-1:0] size,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] remaining,
    output logic          m_req,
    input  logic          m_grant,
    output logic          m_wr,
    output logic [AW-1:0] m_address,
    output logic [DW-1:0] m_dout,
    input  logic [DW-1:0] m_din
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_RD,
        S_RWAIT,
        S_WR,
        S_DONE
    } state_t;

    state_t        state;
    state_t        next_state;
    logic [AW-1:0] sp;
    logic [AW-1:0] dp;
    logic [CW-1:0] rem;
    logic [DW-1:0] data_q;
    logic          zero_done;
    logic          launch;

    assign launch = (state == S_IDLE) && start && (size != {CW{1'b0}});

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Losing the grant anywhere in the read/write cycle discards the word in flight.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (launch) next_state = S_REQ;
            S_REQ:   if (m_grant) next_state = S_RD;
            S_RD:    next_state = m_grant ? S_RWAIT : S_REQ;
            S_RWAIT: next_state = m_grant ? S_WR : S_REQ;
            S_WR: begin
                if (!m_grant) begin
                    next_state = S_REQ;
                end else if (rem == {{(CW-1){1'b0}}, 1'b1}) begin
                    next_state = S_DONE;
                end else begin
                    next_state = S_RD;
                end
            end
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sp        <= {AW{1'b0}};
            dp        <= {AW{1'b0}};
            rem       <= {CW{1'b0}};
            data_q    <= {DW{1'b0}};
            zero_done <= 1'b0;
        end else begin
            zero_done <= (state == S_IDLE) && start && (size == {CW{1'b0}});
            if (launch) begin
                sp  <= src_addr;
                dp  <= dst_addr;
                rem <= size;
            end
            if ((state == S_RWAIT) && m_grant) begin
                data_q <= m_din;
            end
            // Pointers advance only once the write has actually been committed.
            if ((state == S_WR) && m_grant) begin
                sp <= sp + {{(AW-1){1'b0}}, 1'b1};
                dp <= dp + {{(AW-1){1'b0}}, 1'b1};
                if (rem != {CW{1'b0}}) begin
                    rem <= rem - {{(CW-1){1'b0}}, 1'b1};
                end
            end
        end
    end

    always_comb begin
        m_req     = 1'b0;
        m_wr      = 1'b0;
        m_address = {AW{1'b0}};
        m_dout    = {DW{1'b0}};
        busy      = 1'b0;
        done      = zero_done;
        remaining = rem;
        case (state)
            S_REQ: begin
                m_req = 1'b1;
                busy  = 1'b1;
            end
            S_RD, S_RWAIT: begin
                m_req     = 1'b1;
                busy      = 1'b1;
                m_address = sp;
            end
            S_WR: begin
                m_req     = 1'b1;
                busy      = 1'b1;
                m_wr      = 1'b1;
                m_address = dp;
                m_dout    = data_q;
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_bus_dma_master.sv
// Bench for bus_dma_master: a registered-read slave memory and a simple arbiter surround
// the DUT; each copy is compared against a word-by-word block-copy reference model.
module tb_bus_dma_master;
    localparam int AW = 8;
    localparam int DW = 32;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic [AW-1:0] src_addr;
    logic [AW-1:0] dst_addr;
    logic [CW-1:0] size;
    logic          busy;
    logic          done;
    logic [CW-1:0] remaining;
    logic          m_req;
    logic          m_grant;
    logic          m_wr;
    logic [AW-1:0] m_address;
    logic [DW-1:0] m_dout;
    logic [DW-1:0] m_din;

    logic          grant_en;
    logic          drop;
    logic          rand_drop_en;
    logic          rnd_drop;
    logic          gnt_reg;
    logic          load_en;
    logic [AW-1:0] load_addr;
    logic [DW-1:0] load_data;
    logic          log_clear;

    logic [DW-1:0] mem [0:255];
    logic [DW-1:0] ref_mem [0:255];
    logic [DW-1:0] exp_mem [0:255];
    logic [DW-1:0] rd_q;

    int            wr_count;
    int            done_count;
    int            req_count;
    int            cyc;
    logic [AW-1:0] log_addr [0:255];
    logic [DW-1:0] log_data [0:255];
    logic [CW-1:0] log_rem [0:255];
    int            log_cyc [0:255];

    int vectors;
    int miscompares;

    always #5 clk = ~clk;

    bus_dma_master #(.AW(AW), .DW(DW), .CW(CW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .src_addr  (src_addr),
        .dst_addr  (dst_addr),
        .size      (size),
        .busy      (busy),
        .done      (done),
        .remaining (remaining),
        .m_req     (m_req),
        .m_grant   (m_grant),
        .m_wr      (m_wr),
        .m_address (m_address),
        .m_dout    (m_dout),
        .m_din     (m_din)
    );

    // Slave memory, arbiter grant register and transaction log
    always @(posedge clk) begin
        gnt_reg <= m_req && grant_en;
        if (load_en) mem[load_addr] <= load_data;
        else if (m_wr && m_grant) mem[m_address] <= m_dout;
        rd_q <= mem[m_address];
        cyc  <= cyc + 1;
        if (log_clear) begin
            wr_count   <= 0;
            done_count <= 0;
            req_count  <= 0;
        end else begin
            if (m_wr && m_grant) begin
                log_addr[wr_count[7:0]] <= m_address;
                log_data[wr_count[7:0]] <= m_dout;
                log_rem[wr_count[7:0]]  <= remaining;
                log_cyc[wr_count[7:0]]  <= cyc;
                wr_count <= wr_count + 1;
            end
            if (done) done_count <= done_count + 1;
            if (m_req) req_count <= req_count + 1;
        end
    end

    always @(negedge clk) rnd_drop <= rand_drop_en && ($urandom_range(0, 5) == 0);

    assign m_grant = gnt_reg & ~drop & ~rnd_drop;
    assign m_din   = rd_q;

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input logic [AW-1:0] s, input logic [AW-1:0] d,
                                  input logic [CW-1:0] n);
        @(negedge clk);
        src_addr = s;
        dst_addr = d;
        size     = n;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    task automatic load_word(input logic [AW-1:0] a, input logic [DW-1:0] v);
        @(negedge clk);
        load_en   = 1'b1;
        load_addr = a;
        load_data = v;
        ref_mem[a] = v;
        @(negedge clk);
        load_en   = 1'b0;
    endtask

    task automatic fill_memory();
        logic [DW-1:0] v;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            v         = $urandom;
            load_en   = 1'b1;
            load_addr = AW'(i);
            load_data = v;
            ref_mem[i] = v;
        end
        @(negedge clk);
        load_en = 1'b0;
    endtask

    task automatic clear_log();
        @(negedge clk);
        log_clear = 1'b1;
        @(negedge clk);
        log_clear = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int limit);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check_output({tag, "_done_seen"}, 32'(seen), 32'd1);
        repeat (2) @(negedge clk);
    endtask

    // Reference: sequential word copy dst[i] = src[i], addresses modulo 256
    task automatic check_copy(input string tag, input logic [AW-1:0] s, input logic [AW-1:0] d,
                              input int n, input bit timing);
        logic [DW-1:0] exp_w [0:255];
        logic [AW-1:0] sa;
        logic [AW-1:0] da;
        int            bad;
        for (int i = 0; i < 256; i++) exp_mem[i] = ref_mem[i];
        for (int i = 0; i < n; i++) begin
            sa = s + AW'(i);
            da = d + AW'(i);
            exp_mem[da] = exp_mem[sa];
            exp_w[i]    = exp_mem[da];
        end
        check_output({tag, "_writes"}, 32'(wr_count), 32'(n));
        for (int i = 0; i < n && i < wr_count; i++) begin
            check_output($sformatf("%s_waddr%0d", tag, i), 32'(log_addr[i]), 32'(d + AW'(i)));
            check_output($sformatf("%s_wdata%0d", tag, i), log_data[i], exp_w[i]);
            if (timing) begin
                check_output($sformatf("%s_rem%0d", tag, i), 32'(log_rem[i]), 32'(n - i));
                if (i > 0)
                    check_output($sformatf("%s_gap%0d", tag, i),
                                 32'(log_cyc[i] - log_cyc[i-1]), 32'd3);
            end
        end
        bad = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== exp_mem[i]) bad++;
        check_output({tag, "_mem_bad_words"}, 32'(bad), 32'd0);
        check_output({tag, "_done_pulses"}, 32'(done_count), 32'd1);
        check_output({tag, "_req_after"}, 32'(m_req), 32'd0);
        check_output({tag, "_busy_after"}, 32'(busy), 32'd0);
        check_output({tag, "_remaining_after"}, 32'(remaining), 32'd0);
        for (int i = 0; i < 256; i++) ref_mem[i] = exp_mem[i];
    endtask

    initial begin
        bit seen;
        logic [AW-1:0] rs;
        logic [AW-1:0] rd;
        logic [CW-1:0] rn;

        vectors      = 0;
        miscompares  = 0;
        reset_n      = 1'b0;
        start        = 1'b0;
        src_addr     = '0;
        dst_addr     = '0;
        size         = '0;
        grant_en     = 1'b0;
        drop         = 1'b0;
        rand_drop_en = 1'b0;
        load_en      = 1'b0;
        load_addr    = '0;
        load_data    = '0;
        log_clear    = 1'b1;

        repeat (3) @(negedge clk);
        check_output("rst_m_req", 32'(m_req), 32'd0);
        check_output("rst_m_wr", 32'(m_wr), 32'd0);
        check_output("rst_m_address", 32'(m_address), 32'd0);
        check_output("rst_m_dout", m_dout, 32'd0);
        check_output("rst_busy", 32'(busy), 32'd0);
        check_output("rst_done", 32'(done), 32'd0);
        check_output("rst_remaining", 32'(remaining), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        log_clear = 1'b0;
        fill_memory();
        grant_en = 1'b1;

        $display("[TB] single word copy");
        load_word(8'h00, 32'hDEADBEEF);
        clear_log();
        apply_stimulus(8'h00, 8'h10, 8'd1);
        check_output("t2_busy_start", 32'(busy), 32'd1);
        check_output("t2_req_start", 32'(m_req), 32'd1);
        wait_done("t2", 50);
        check_copy("t2", 8'h00, 8'h10, 1, 1'b0);
        check_output("t2_dst_value", mem[8'h10], 32'hDEADBEEF);

        $display("[TB] four word copy, grant held");
        clear_log();
        apply_stimulus(8'h00, 8'h20, 8'd4);
        wait_done("t3", 60);
        check_copy("t3", 8'h00, 8'h20, 4, 1'b1);

        $display("[TB] source wrap");
        clear_log();
        apply_stimulus(8'hFE, 8'h80, 8'd3);
        wait_done("t4", 60);
        check_copy("t4", 8'hFE, 8'h80, 3, 1'b1);

        $display("[TB] zero size");
        clear_log();
        apply_stimulus(8'h33, 8'h44, 8'd0);
        check_output("t5_done_next", 32'(done), 32'd1);
        check_output("t5_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check_output("t5_done_once", 32'(done), 32'd0);
        repeat (3) @(negedge clk);
        check_output("t5_req_cycles", 32'(req_count), 32'd0);
        check_output("t5_writes", 32'(wr_count), 32'd0);
        check_output("t5_done_pulses", 32'(done_count), 32'd1);

        $display("[TB] grant loss in read wait of word 2");
        clear_log();
        apply_stimulus(8'h40, 8'h60, 8'd5);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (wr_count == 1) begin
                seen = 1'b1;
                break;
            end
        end
        check_output("t6_first_write", 32'(seen), 32'd1);
        @(negedge clk);
        check_output("t6_rwait_addr", 32'(m_address), 32'h41);
        check_output("t6_rwait_wr", 32'(m_wr), 32'd0);
        drop     = 1'b1;
        src_addr = 8'h00;
        dst_addr = 8'h00;
        size     = 8'd7;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drop  = 1'b0;
        check_output("t6_req_held", 32'(m_req), 32'd1);
        check_output("t6_req_addr", 32'(m_address), 32'd0);
        check_output("t6_rem_kept", 32'(remaining), 32'd4);
        wait_done("t6", 80);
        check_copy("t6", 8'h40, 8'h60, 5, 1'b0);

        $display("[TB] reset during write");
        clear_log();
        apply_stimulus(8'h90, 8'hA0, 8'd6);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (m_wr) begin
                seen = 1'b1;
                break;
            end
        end
        check_output("t1_reached_wr", 32'(seen), 32'd1);
        #1 reset_n = 1'b0;
        #1;
        check_output("t1_req_now", 32'(m_req), 32'd0);
        check_output("t1_wr_now", 32'(m_wr), 32'd0);
        check_output("t1_rem_now", 32'(remaining), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        check_output("t1_busy_after", 32'(busy), 32'd0);
        check_output("t1_req_after", 32'(m_req), 32'd0);
        check_output("t1_writes", 32'(wr_count), 32'd0);

        $display("[TB] randomized copies");
        for (int k = 0; k < 6; k++) begin
            fill_memory();
            rand_drop_en = k[0];
            rs = AW'($urandom);
            rd = AW'($urandom);
            rn = CW'($urandom_range(1, 24));
            clear_log();
            apply_stimulus(rs, rd, rn);
            wait_done($sformatf("rnd%0d", k), 2000);
            check_copy($sformatf("rnd%0d", k), rs, rd, int'(rn), 1'b0);
        end
        rand_drop_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
